calc_entry_fsm: RTL and testbench

Key-event consumer for the calculator, sitting between `keyb_iface` and the arithmetic unit. It turns one-shot detections of keypad `btn_press` pulses into BCD digit entry for two operands, captures the operator, and issues a compute request on `=`. It also holds the returned result for display and exposes the value currently being shown.

---
 rtl/calc_entry_fsm_pkg.sv | 21 ++
 rtl/calc_entry_fsm_if.sv | 40 ++++
 rtl/bcd_entry_reg.sv | 58 +++++
 rtl/calc_entry_fsm.sv | 170 +++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/calc_entry_fsm_pkg.sv
// calc_pkg: shared constants and types for the calculator key-entry block.
//   OP_NONE/OP_ADD/OP_SUB : operator encodings carried on op_code
//   DigitW                : bits per BCD digit
//   calc_state_e          : entry FSM states
package calc_pkg;

  localparam int unsigned DigitW = 4;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_ADD  = 2'd1;
  localparam logic [1:0] OP_SUB  = 2'd2;

  typedef enum logic [2:0] {
    StEnterA,
    StOpWait,
    StEnterB,
    StCalc,
    StShowResult
  } calc_state_e;

endpackage

// File: rtl/calc_entry_fsm_if.sv
// calc_entry_if: key-event inputs, arithmetic-unit handshake and display outputs of
// calc_entry_fsm bundled into one interface.
//   master : the entry FSM side (consumes keys/ack, drives request/operands/display)
//   slave  : the environment side (keypad front end, arithmetic unit, display)
interface calc_entry_if #(
  parameter int unsigned NumDigits = 4
);
  import calc_pkg::*;

  localparam int unsigned W = DigitW * NumDigits;

  // Keypad event fields
  logic         btn_press;
  logic         is_number;
  logic         is_op;
  logic         is_eq;
  logic [3:0]   num_val;
  logic [1:0]   op_val;
  // Arithmetic unit handshake
  logic         calc_req;
  logic         calc_ack;
  logic [W-1:0] result_bcd;
  logic [W-1:0] operand_a;
  logic [W-1:0] operand_b;
  logic [1:0]   op_code;
  // Display / status
  logic [W-1:0] disp_bcd;
  logic         busy;

  modport master (
    input  btn_press, is_number, is_op, is_eq, num_val, op_val, calc_ack, result_bcd,
    output calc_req, operand_a, operand_b, op_code, disp_bcd, busy
  );

  modport slave (
    output btn_press, is_number, is_op, is_eq, num_val, op_val, calc_ack, result_bcd,
    input  calc_req, operand_a, operand_b, op_code, disp_bcd, busy
  );

endinterface

// File: rtl/bcd_entry_reg.sv
// bcd_entry_reg: BCD operand shift register with digit counter.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : zero value and count (combines with digit_i: clear, then shift)
//   load_i        : parallel load of load_val_i / load_cnt_i (wins over digit_i)
//   digit_i       : shift digit_val_i in at the least significant digit
//   value_o       : current operand value
// Leading zeros do not consume a digit slot; digits beyond NumDigits are dropped.
module bcd_entry_reg
  import calc_pkg::*;
#(
  parameter int unsigned NumDigits = 4,
  localparam int unsigned W        = DigitW * NumDigits,
  localparam int unsigned CntW     = $clog2(NumDigits + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            clear_i,
  input  logic            load_i,
  input  logic [W-1:0]    load_val_i,
  input  logic [CntW-1:0] load_cnt_i,
  input  logic            digit_i,
  input  logic [3:0]      digit_val_i,
  output logic [W-1:0]    value_o
);

  logic [W-1:0]    value_q, value_d, base_val;
  logic [CntW-1:0] cnt_q, cnt_d, base_cnt;

  always_comb begin
    base_val = clear_i ? '0 : value_q;
    base_cnt = clear_i ? '0 : cnt_q;
    value_d  = base_val;
    cnt_d    = base_cnt;
    if (load_i) begin
      value_d = load_val_i;
      cnt_d   = load_cnt_i;
    end else if (digit_i && (base_cnt < CntW'(NumDigits))) begin
      // A zero typed before any significant digit changes nothing.
      if (!((base_cnt == '0) && (digit_val_i == 4'd0))) begin
        value_d = {base_val[W-DigitW-1:0], digit_val_i};
        cnt_d   = base_cnt + CntW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= '0;
      cnt_q   <= '0;
    end else begin
      value_q <= value_d;
      cnt_q   <= cnt_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/calc_entry_fsm.sv
// calc_entry_fsm: turns keypad press events into two BCD operands and an operator,
// requests a computation on '=', and holds the returned result for display.
//   clk_i, rst_ni : clock, async active-low reset
//   bus_io        : calc_entry_if master (key fields, calc_req/calc_ack handshake,
//                   operands, op_code, disp_bcd, busy)
// Build option CALC_CHAIN_EN: an operator key while showing a result loads the result
// into operand A and continues with that operator.
module calc_entry_fsm
  import calc_pkg::*;
#(
  parameter int unsigned NumDigits = 4
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  calc_entry_if.master bus_io
);

  localparam int unsigned W    = DigitW * NumDigits;
  localparam int unsigned CntW = $clog2(NumDigits + 1);

  calc_state_e state_q, state_d;
  logic [1:0]   op_q, op_d;
  logic [W-1:0] result_q, result_d;
  logic         press_q;
  // Low for the first cycle after reset so a key held across reset is not an event.
  logic         armed_q;

  logic key_ev, key_digit, key_op, key_eq;
  logic a_clr, a_dig, a_load, b_clr, b_dig;
  logic [W-1:0]    a_val, b_val;
  logic [CntW-1:0] a_load_cnt;

  assign key_ev    = bus_io.btn_press & ~press_q & armed_q;
  assign key_digit = key_ev & bus_io.is_number & (bus_io.num_val <= 4'd9);
  assign key_op    = key_ev & ~bus_io.is_number & bus_io.is_op &
                     ((bus_io.op_val == OP_ADD) || (bus_io.op_val == OP_SUB));
  assign key_eq    = key_ev & ~bus_io.is_number & ~bus_io.is_op & bus_io.is_eq;

`ifdef CALC_CHAIN_EN
  // Position of the most significant non-zero digit, 0 for a zero value.
  function automatic logic [CntW-1:0] sig_digits(input logic [W-1:0] v);
    logic [CntW-1:0] n;
    n = '0;
    for (int unsigned i = 0; i < NumDigits; i++) begin
      if (v[i*DigitW +: DigitW] != '0) n = CntW'(i + 1);
    end
    return n;
  endfunction

  assign a_load_cnt = sig_digits(result_q);
`else
  assign a_load_cnt = '0;
`endif

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    result_d = result_q;
    a_clr    = 1'b0;
    a_dig    = 1'b0;
    a_load   = 1'b0;
    b_clr    = 1'b0;
    b_dig    = 1'b0;
    unique case (state_q)
      StEnterA: begin
        if (key_digit) begin
          a_dig = 1'b1;
        end else if (key_op) begin
          op_d    = bus_io.op_val;
          state_d = StOpWait;
        end
      end
      StOpWait: begin
        if (key_op) begin
          op_d = bus_io.op_val;
        end else if (key_digit) begin
          b_clr   = 1'b1;
          b_dig   = 1'b1;
          state_d = StEnterB;
        end
      end
      StEnterB: begin
        if (key_digit) begin
          b_dig = 1'b1;
        end else if (key_eq) begin
          state_d = StCalc;
        end
      end
      StCalc: begin
        if (bus_io.calc_ack) begin
          result_d = bus_io.result_bcd;
          state_d  = StShowResult;
        end
      end
      StShowResult: begin
        if (key_digit) begin
          a_clr   = 1'b1;
          b_clr   = 1'b1;
          a_dig   = 1'b1;
          state_d = StEnterA;
        end
`ifdef CALC_CHAIN_EN
        else if (key_op) begin
          a_load  = 1'b1;
          op_d    = bus_io.op_val;
          state_d = StOpWait;
        end
`endif
      end
      default: state_d = StEnterA;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StEnterA;
      op_q     <= OP_NONE;
      result_q <= '0;
      press_q  <= 1'b0;
      armed_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      result_q <= result_d;
      press_q  <= bus_io.btn_press;
      armed_q  <= 1'b1;
    end
  end

  bcd_entry_reg #(.NumDigits(NumDigits)) u_reg_a (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (a_clr),
    .load_i     (a_load),
    .load_val_i (result_q),
    .load_cnt_i (a_load_cnt),
    .digit_i    (a_dig),
    .digit_val_i(bus_io.num_val),
    .value_o    (a_val)
  );

  bcd_entry_reg #(.NumDigits(NumDigits)) u_reg_b (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clear_i    (b_clr),
    .load_i     (1'b0),
    .load_val_i ('0),
    .load_cnt_i ('0),
    .digit_i    (b_dig),
    .digit_val_i(bus_io.num_val),
    .value_o    (b_val)
  );

  // Request is a pure decode of the state so an async reset drops it immediately.
  assign bus_io.calc_req  = (state_q == StCalc);
  assign bus_io.busy      = (state_q == StCalc);
  assign bus_io.operand_a = a_val;
  assign bus_io.operand_b = b_val;
  assign bus_io.op_code   = op_q;

  always_comb begin
    bus_io.disp_bcd = a_val;
    unique case (state_q)
      StEnterB, StCalc: bus_io.disp_bcd = b_val;
      StShowResult:     bus_io.disp_bcd = result_q;
      default:          bus_io.disp_bcd = a_val;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_fsm.sv
// Directed bench for calc_entry_fsm. Inputs change and outputs are sampled on the
// falling clock edge; the design acts on the rising edge.
module tb_calc_entry_fsm;
  import calc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  calc_entry_if #(.NumDigits(4)) bus ();

  calc_entry_fsm #(.NumDigits(4)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus_io(bus)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic key_down(input logic num, input logic op, input logic eq,
                          input logic [3:0] nv, input logic [1:0] ov);
    bus.is_number = num;
    bus.is_op     = op;
    bus.is_eq     = eq;
    bus.num_val   = nv;
    bus.op_val    = ov;
    bus.btn_press = 1'b1;
  endtask

  task automatic key_up();
    bus.btn_press = 1'b0;
    bus.is_number = 1'b0;
    bus.is_op     = 1'b0;
    bus.is_eq     = 1'b0;
    bus.num_val   = 4'd0;
    bus.op_val    = 2'd0;
  endtask

  // Full press: held 5 cycles, then 2 idle cycles.
  task automatic press(input logic num, input logic op, input logic eq,
                       input logic [3:0] nv, input logic [1:0] ov);
    key_down(num, op, eq, nv, ov);
    tick(5);
    key_up();
    tick(2);
  endtask

  task automatic digit(input logic [3:0] d);
    press(1'b1, 1'b0, 1'b0, d, 2'd0);
  endtask

  task automatic oper(input logic [1:0] o);
    press(1'b0, 1'b1, 1'b0, 4'd0, o);
  endtask

  task automatic equals();
    press(1'b0, 1'b0, 1'b1, 4'd0, 2'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin
    key_up();
    bus.calc_ack   = 1'b0;
    bus.result_bcd = '0;
    tick(3);
    check_eq("rst_calc_req", bus.calc_req, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_op_code", bus.op_code, 0);
    check_eq("rst_a", bus.operand_a, 0);
    check_eq("rst_b", bus.operand_b, 0);
    check_eq("rst_disp", bus.disp_bcd, 0);
    rst_n = 1'b1;
    tick(1);

    // 1 2 + 3 =
    digit(4'd1);
    digit(4'd2);
    check_eq("t1_a", bus.operand_a, 32'h12);
    check_eq("t1_disp_a", bus.disp_bcd, 32'h12);
    oper(OP_ADD);
    check_eq("t1_op", bus.op_code, 1);
    check_eq("t1_disp_opwait", bus.disp_bcd, 32'h12);
    digit(4'd3);
    check_eq("t1_b", bus.operand_b, 32'h3);
    check_eq("t1_disp_b", bus.disp_bcd, 32'h3);
    key_down(1'b0, 1'b0, 1'b1, 4'd0, 2'd0);
    check_eq("t1_req_before_eq", bus.calc_req, 0);
    tick(1);
    check_eq("t1_req_after_eq", bus.calc_req, 1);
    check_eq("t1_busy", bus.busy, 1);
    tick(4);
    key_up();
    tick(2);
    // keys during CALC ignored
    digit(4'd7);
    equals();
    check_eq("t1_calc_b_stable", bus.operand_b, 32'h3);
    check_eq("t1_calc_a_stable", bus.operand_a, 32'h12);
    check_eq("t1_calc_op_stable", bus.op_code, 1);
    check_eq("t1_calc_req_held", bus.calc_req, 1);
    bus.calc_ack   = 1'b1;
    bus.result_bcd = 16'h0015;
    tick(0);
    check_eq("t1_req_in_ack_cycle", bus.calc_req, 1);
    tick(1);
    bus.calc_ack   = 1'b0;
    bus.result_bcd = 16'h0099;
    check_eq("t1_req_after_ack", bus.calc_req, 0);
    check_eq("t1_busy_after_ack", bus.busy, 0);
    check_eq("t1_disp_result", bus.disp_bcd, 32'h15);
    tick(1);
    check_eq("t1_result_held", bus.disp_bcd, 32'h15);

    // Operator in SHOW_RESULT, then a digit
    oper(OP_ADD);
`ifdef CALC_CHAIN_EN
    check_eq("t5_chain_a", bus.operand_a, 32'h15);
    check_eq("t5_chain_disp", bus.disp_bcd, 32'h15);
    digit(4'd9);
    check_eq("t5_chain_b", bus.operand_b, 32'h9);
    check_eq("t5_chain_a_keep", bus.operand_a, 32'h15);
`else
    check_eq("t5_nochain_disp", bus.disp_bcd, 32'h15);
    check_eq("t5_nochain_a", bus.operand_a, 32'h12);
    digit(4'd9);
    check_eq("t5_new_a", bus.operand_a, 32'h9);
    check_eq("t5_new_b", bus.operand_b, 32'h0);
    check_eq("t5_new_disp", bus.disp_bcd, 32'h9);
`endif

    // Leading zeros and full operand
    do_reset();
    digit(4'd0);
    digit(4'd0);
    check_eq("t2_lead_zero", bus.operand_a, 32'h0);
    digit(4'd7);
    digit(4'd1);
    digit(4'd2);
    digit(4'd3);
    check_eq("t2_full", bus.operand_a, 32'h7123);
    digit(4'd4);
    check_eq("t2_overflow", bus.operand_a, 32'h7123);
    check_eq("t2_disp", bus.disp_bcd, 32'h7123);

    // + - 5 = from reset, with ignored and invalid keys
    do_reset();
    equals();
    check_eq("t3_eq_entera", bus.busy, 0);
    oper(OP_ADD);
    oper(OP_SUB);
    check_eq("t3_op_replaced", bus.op_code, 2);
    check_eq("t3_a_zero", bus.operand_a, 0);
    equals();
    check_eq("t3_eq_opwait", bus.busy, 0);
    digit(4'd5);
    check_eq("t3_b", bus.operand_b, 32'h5);
    digit(4'd10);
    press(1'b0, 1'b1, 1'b0, 4'd0, 2'd3);
    press(1'b0, 1'b0, 1'b0, 4'd6, 2'd0);
    check_eq("t3_invalid_b", bus.operand_b, 32'h5);
    check_eq("t3_invalid_op", bus.op_code, 2);
    equals();
    check_eq("t3_req", bus.calc_req, 1);

    // Async reset during CALC, key held across reset release
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_req_async", bus.calc_req, 0);
    check_eq("t6_busy_async", bus.busy, 0);
    bus.calc_ack   = 1'b1;
    bus.result_bcd = 16'h0042;
    key_down(1'b1, 1'b0, 1'b0, 4'd8, 2'd0);
    tick(2);
    rst_n = 1'b1;
    tick(4);
    check_eq("t6_ack_ignored_disp", bus.disp_bcd, 0);
    check_eq("t6_ack_ignored_req", bus.calc_req, 0);
    check_eq("t6_held_key_a", bus.operand_a, 0);
    bus.calc_ack = 1'b0;
    key_up();
    tick(2);
    digit(4'd8);
    check_eq("t6_fresh_key", bus.operand_a, 32'h8);
    // Ack outside CALC is ignored
    bus.calc_ack   = 1'b1;
    bus.result_bcd = 16'h0099;
    tick(2);
    bus.calc_ack = 1'b0;
    tick(1);
    check_eq("t6_stray_ack", bus.disp_bcd, 32'h8);
    check_eq("t6_stray_busy", bus.busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
